booth_step_ctrl: RTL and testbench
==================================

Name: booth_step_ctrl

Overview:
Radix-2 Booth sequencer for signed WIDTH_IN x WIDTH_IN multiplication.
- Latches the operands on a start request and runs WIDTH_IN add/sub + arithmetic-shift-right steps on a WIDTH_PP-bit partial-product word.
- Sits directly upstream of the partial-product register: drives its next-value bus and its load/step strobes, and reports the final product with a done pulse.
- Keeps an internal shadow of the partial-product word so it is self-contained.

Parameters:
- WIDTH_IN, 16, operand width (multiplicand and multiplier, two's complement).
- WIDTH_PP, 33, partial-product width; must equal 2*WIDTH_IN+1.
- CNT_W, 5, step-counter width; must equal $clog2(WIDTH_IN)+1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk only).
- start_i  in  1  start request; honoured only in IDLE.
- a_i  in  WIDTH_IN  multiplicand, signed.
- b_i  in  WIDTH_IN  multiplier, signed.
- busy_o  out  1  high from the accepting edge until DONE exits.
- done_o  out  1  one-cycle pulse; product_o is valid in that cycle.
- product_o  out  2*WIDTH_IN  signed product; held until the next accepted start.
- pp_next_o  out  WIDTH_PP  next partial-product value for the downstream register.
- en_load_o  out  1  downstream load strobe (initial value).
- en_step_o  out  1  downstream step strobe (iterated value).

Behaviour:
- Single clock domain. Reset (reset==0 at a rising edge) forces the following, regardless of state, including mid-multiply; no partial result survives:
  - state=IDLE, count=0, pp=0, a_reg=0, product_o=0, done_o=0, busy_o=0.
- FSM states and transitions:
  - IDLE: busy_o=0. If start_i==1, at the edge: a_reg<=a_i; pp<={WIDTH_IN zeros, b_i, 1'b0}; count<=0; go to STEP.
  - STEP: busy_o=1. Each edge performs one Booth step on pp and increments count. When count==WIDTH_IN-1, the step is performed and the FSM goes to DONE.
  - DONE: busy_o=1, done_o=1, product_o<=pp[WIDTH_PP-1:1] (registered on entry, so visible during DONE). Next edge unconditionally returns to IDLE.
- Booth step. Let hi = pp[WIDTH_PP-1:WIDTH_IN+1] (WIDTH_IN bits) and lo = pp[WIDTH_IN:0].
  - pp[1:0]=01: sum = sext(hi,WIDTH_IN+1) + sext(a_reg,WIDTH_IN+1).
  - pp[1:0]=10: sum = sext(hi,WIDTH_IN+1) - sext(a_reg,WIDTH_IN+1).
  - pp[1:0]=00 or 11: sum = sext(hi,WIDTH_IN+1).
  - pp_new = {sum, lo[WIDTH_IN:1]}. The (WIDTH_IN+1)-bit sum absorbs the shift-in sign bit, so there is no overflow even for a=b=-2^(WIDTH_IN-1).
- Latency: the start is accepted at edge N; done_o is high in the cycle after edge N+WIDTH_IN (16 cycles for the defaults). The next start can be accepted at edge N+WIDTH_IN+2. Throughput is one product per WIDTH_IN+2 cycles.
- Downstream strobes are combinational from state/inputs:
  - en_load_o = (state==IDLE) & start_i & reset; pp_next_o = load value.
  - en_step_o = (state==STEP); pp_next_o = pp_new.
  - Otherwise pp_next_o = pp, and both strobes are 0.
  - en_load_o and en_step_o are never high together.
- start_i in STEP or DONE is ignored; no queueing.
- start_i held high continuously restarts at every IDLE visit, using a_i/b_i sampled at that edge.
- Operands changing after acceptance have no effect.

Decomposition:
- Package booth_pkg:
  - typedef enum logic [1:0] {IDLE, STEP, DONE} booth_state_e.
  - Localparams WIDTH_IN, WIDTH_PP, CNT_W.
  - Booth-code constants BOOTH_ADD=2'b01, BOOTH_SUB=2'b10.
- Sub-module booth_addsub_shift: purely combinational, (pp, a_reg) -> pp_new, holding the step arithmetic above.
- The FSM, counter, operand/product registers and strobes stay in booth_step_ctrl.

Test Plan:
- Reset, then a_i=3, b_i=5, start 1 cycle -> en_load_o pulses with pp_next_o=0x0000_000A; done_o 16 cycles after acceptance; product_o=0x0000000F.
- a_i=-7 (0xFFF9), b_i=6 -> product_o=0xFFFFFFD6 (-42); en_step_o high for exactly 16 consecutive cycles.
- a_i=b_i=0x8000 -> product_o=0x40000000. Also a_i=0x7FFF, b_i=0x8000 -> product_o=0xC0008000.
- Start 20x20; pulse start_i with 1x1 during step 5; change a_i/b_i mid-run -> product_o=0x00000190, no second done_o.
- Assert reset at step 8 of 100x100 -> next cycle busy_o=0, product_o=0, done_o never fires. A new start with 2x-3 -> 0xFFFFFFFA.
- start_i held high for three products (1x1, -1x-1, 0x1234) -> done_o spaced exactly 18 cycles apart; products 1, 1, 0.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared widths, FSM state type and Booth recoding constants for the
// radix-2 Booth sequencer.
package booth_pkg;

  localparam int unsigned WIDTH_IN = 16;
  localparam int unsigned WIDTH_PP = 2 * WIDTH_IN + 1;
  localparam int unsigned CNT_W    = $clog2(WIDTH_IN) + 1;

  typedef enum logic [1:0] {IDLE, STEP, DONE} booth_state_e;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step_ctrl_if.sv
// Request/result and downstream partial-product bus of the Booth sequencer.
interface booth_step_ctrl_if;
  import booth_pkg::*;

  logic                  start_i;
  logic [WIDTH_IN-1:0]   a_i;
  logic [WIDTH_IN-1:0]   b_i;
  logic                  busy_o;
  logic                  done_o;
  logic [2*WIDTH_IN-1:0] product_o;
  logic [WIDTH_PP-1:0]   pp_next_o;
  logic                  en_load_o;
  logic                  en_step_o;

  modport master (
    output start_i, a_i, b_i,
    input  busy_o, done_o, product_o, pp_next_o, en_load_o, en_step_o
  );

  modport slave (
    input  start_i, a_i, b_i,
    output busy_o, done_o, product_o, pp_next_o, en_load_o, en_step_o
  );

endinterface

// File: rtl/booth_addsub_shift.sv
// One radix-2 Booth step: conditional add/sub of the multiplicand into the
// upper half, then arithmetic shift right by one.
module booth_addsub_shift
  import booth_pkg::*;
(
  input  logic [WIDTH_PP-1:0] pp_i,
  input  logic [WIDTH_IN-1:0] a_reg_i,
  output logic [WIDTH_PP-1:0] pp_new_o
);

  logic [WIDTH_IN:0] hi_ext;
  logic [WIDTH_IN:0] a_ext;
  logic [WIDTH_IN:0] sum;

  // One extra bit of headroom carries the shifted-in sign, so -2^(N-1) squared cannot overflow.
  assign hi_ext = {pp_i[WIDTH_PP-1], pp_i[WIDTH_PP-1:WIDTH_IN+1]};
  assign a_ext  = {a_reg_i[WIDTH_IN-1], a_reg_i};

  always_comb begin
    sum = hi_ext;
    case (pp_i[1:0])
      BOOTH_ADD: sum = hi_ext + a_ext;
      BOOTH_SUB: sum = hi_ext - a_ext;
      default:   sum = hi_ext;
    endcase
  end

  assign pp_new_o = {sum, pp_i[WIDTH_IN:1]};

endmodule

// File: rtl/booth_step_ctrl.sv
// Radix-2 Booth multiply sequencer: latches operands, runs WIDTH_IN steps on a
// shadow partial-product word and drives the downstream register strobes.
module booth_step_ctrl
  import booth_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  booth_step_ctrl_if.slave   bus
);

  booth_state_e          state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [WIDTH_PP-1:0]   pp_q, pp_d;
  logic [WIDTH_PP-1:0]   pp_new;
  logic [WIDTH_PP-1:0]   pp_load;
  logic [WIDTH_IN-1:0]   a_q, a_d;
  logic [2*WIDTH_IN-1:0] product_q, product_d;
  logic                  last_step;
  logic                  load;

  booth_addsub_shift u_addsub_shift (
    .pp_i     (pp_q),
    .a_reg_i  (a_q),
    .pp_new_o (pp_new)
  );

  assign pp_load   = {{WIDTH_IN{1'b0}}, bus.b_i, 1'b0};
  assign last_step = (count_q == CNT_W'(WIDTH_IN - 1));
  assign load      = (state_q == IDLE) && bus.start_i && reset;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pp_d      = pp_q;
    a_d       = a_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          a_d     = bus.a_i;
          pp_d    = pp_load;
          count_d = '0;
          state_d = STEP;
        end
      end
      STEP: begin
        pp_d    = pp_new;
        count_d = count_q + CNT_W'(1);
        if (last_step) begin
          state_d   = DONE;
          product_d = pp_new[WIDTH_PP-1:1];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      pp_q      <= '0;
      a_q       <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pp_q      <= pp_d;
      a_q       <= a_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    bus.en_load_o = load;
    bus.en_step_o = (state_q == STEP);
    if (load) begin
      bus.pp_next_o = pp_load;
    end else if (state_q == STEP) begin
      bus.pp_next_o = pp_new;
    end else begin
      bus.pp_next_o = pp_q;
    end
  end

  assign bus.busy_o    = (state_q != IDLE);
  assign bus.done_o    = (state_q == DONE);
  assign bus.product_o = product_q;

endmodule

// File: tb/tb_booth_step_ctrl.sv
// Self-checking bench for booth_step_ctrl against a plain signed-multiply model.
module tb_booth_step_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  booth_step_ctrl_if bus ();

  booth_step_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
    int pa;
    int pb;
    pa = $signed(a);
    pb = $signed(b);
    return 32'(pa * pb);
  endfunction

  function automatic logic [32:0] ref_load(input logic [15:0] b);
    return {16'h0000, b, 1'b0};
  endfunction

  // Runs one multiply and reports what was observed; checks are in the callers.
  task automatic do_mult(input logic [15:0] a, input logic [15:0] b,
                         output logic load_en, output logic [32:0] load_val,
                         output int lat, output int steps, output logic busy_done,
                         output logic [31:0] prod);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.a_i     = a;
    bus.b_i     = b;
    #1;
    load_en  = bus.en_load_o;
    load_val = bus.pp_next_o;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.a_i     = 16'($urandom);
    bus.b_i     = 16'($urandom);
    lat       = -1;
    steps     = 0;
    busy_done = 1'b0;
    prod      = 'x;
    for (int k = 1; k <= 40; k++) begin
      if (bus.en_step_o) steps++;
      if (bus.done_o) begin
        lat       = k - 1;
        busy_done = bus.busy_o;
        prod      = bus.product_o;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset       = 1'b0;
    bus.start_i = 1'b1;
    bus.a_i     = 16'h1234;
    bus.b_i     = 16'h5678;
    #1;
    checks++;
    if (bus.en_load_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_load_gate: en_load_o=%b required 0", bus.en_load_o);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.en_step_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: busy=%b done=%b step=%b required 0 0 0",
               bus.busy_o, bus.done_o, bus.en_step_o);
    end
    checks++;
    if (bus.product_o !== 32'h0 || bus.pp_next_o !== 33'h0) begin
      failures++;
      $display("FAIL reset_values: product=%h pp_next=%h required 0 0",
               bus.product_o, bus.pp_next_o);
    end
    bus.start_i = 1'b0;
    reset       = 1'b1;
  endtask

  task automatic test_basic();
    logic le; logic [32:0] lv; int lat; int st; logic bd; logic [31:0] p;
    do_mult(16'd3, 16'd5, le, lv, lat, st, bd, p);
    checks++;
    if (le !== 1'b1 || lv !== ref_load(16'd5)) begin
      failures++;
      $display("FAIL basic_load: en_load=%b pp_next=%h required 1 %h", le, lv, ref_load(16'd5));
    end
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL basic_latency: got %0d required 16", lat);
    end
    checks++;
    if (p !== ref_prod(16'd3, 16'd5) || bd !== 1'b1) begin
      failures++;
      $display("FAIL basic_product: product=%h busy=%b required %h 1", p, bd, ref_prod(16'd3, 16'd5));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.product_o !== 32'h0000000F || bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_hold: product=%h done=%b busy=%b required 0000000f 0 0",
               bus.product_o, bus.done_o, bus.busy_o);
    end
  endtask

  task automatic test_negative();
    logic le; logic [32:0] lv; int lat; int st; logic bd; logic [31:0] p;
    do_mult(16'hFFF9, 16'd6, le, lv, lat, st, bd, p);
    checks++;
    if (p !== 32'hFFFFFFD6) begin
      failures++;
      $display("FAIL neg_product: got %h required ffffffd6", p);
    end
    checks++;
    if (st !== 16) begin
      failures++;
      $display("FAIL neg_step_cycles: got %0d required 16", st);
    end
  endtask

  task automatic test_corners();
    logic le; logic [32:0] lv; int lat; int st; logic bd; logic [31:0] p;
    do_mult(16'h8000, 16'h8000, le, lv, lat, st, bd, p);
    checks++;
    if (p !== 32'h40000000) begin
      failures++;
      $display("FAIL corner_minmin: got %h required 40000000", p);
    end
    do_mult(16'h7FFF, 16'h8000, le, lv, lat, st, bd, p);
    checks++;
    if (p !== 32'hC0008000) begin
      failures++;
      $display("FAIL corner_maxmin: got %h required c0008000", p);
    end
  endtask

  task automatic test_ignore_start();
    int   dones;
    logic load_seen;
    logic [31:0] p;
    dones     = 0;
    load_seen = 1'b0;
    p         = 'x;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.a_i     = 16'd20;
    bus.b_i     = 16'd20;
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 5) begin
        bus.start_i = 1'b1;
        bus.a_i     = 16'd1;
        bus.b_i     = 16'd1;
        #1;
        if (bus.en_load_o) load_seen = 1'b1;
      end
      if (k == 6) begin
        bus.start_i = 1'b0;
        bus.a_i     = 16'($urandom);
        bus.b_i     = 16'($urandom);
      end
      if (bus.done_o) begin
        if (dones == 0) p = bus.product_o;
        dones++;
      end
      @(negedge clk);
    end
    checks++;
    if (load_seen !== 1'b0) begin
      failures++;
      $display("FAIL ignore_load: en_load_o seen during busy, required none");
    end
    checks++;
    if (p !== 32'h00000190) begin
      failures++;
      $display("FAIL ignore_product: got %h required 00000190", p);
    end
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL ignore_done_count: got %0d required 1", dones);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    logic le; logic [32:0] lv; int lat; int st; logic bd; logic [31:0] p;
    dones = 0;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.a_i     = 16'd100;
    bus.b_i     = 16'd100;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.product_o !== 32'h0 || bus.done_o !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state: busy=%b product=%h done=%b required 0 0 0",
               bus.busy_o, bus.product_o, bus.done_o);
    end
    reset = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.done_o) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL midreset_no_done: got %0d dones required 0", dones);
    end
    do_mult(16'd2, 16'hFFFD, le, lv, lat, st, bd, p);
    checks++;
    if (p !== 32'hFFFFFFFA || lat !== 16) begin
      failures++;
      $display("FAIL midreset_restart: product=%h latency=%0d required fffffffa 16", p, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] oa [3];
    logic [15:0] ob [3];
    int idx;
    int cyc;
    int last;
    oa[0] = 16'd1;    ob[0] = 16'd1;
    oa[1] = 16'hFFFF; ob[1] = 16'hFFFF;
    oa[2] = 16'h0000; ob[2] = 16'h1234;
    idx  = 0;
    cyc  = 0;
    last = -1;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.a_i     = oa[0];
    bus.b_i     = ob[0];
    for (int k = 0; k < 120 && idx < 3; k++) begin
      @(negedge clk);
      cyc++;
      if (bus.done_o) begin
        checks++;
        if (bus.product_o !== ref_prod(oa[idx], ob[idx])) begin
          failures++;
          $display("FAIL b2b_product%0d: got %h required %h", idx, bus.product_o,
                   ref_prod(oa[idx], ob[idx]));
        end
        if (idx > 0) begin
          checks++;
          if (cyc - last != 18) begin
            failures++;
            $display("FAIL b2b_spacing%0d: got %0d required 18", idx, cyc - last);
          end
        end
        last = cyc;
        idx++;
        if (idx < 3) begin
          bus.a_i = oa[idx];
          bus.b_i = ob[idx];
        end
      end
    end
    bus.start_i = 1'b0;
    if (idx < 3) begin
      checks++;
      failures++;
      $display("FAIL b2b_timeout: saw %0d products required 3", idx);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    logic le; logic [32:0] lv; int lat; int st; logic bd; logic [31:0] p;
    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      do_mult(a, b, le, lv, lat, st, bd, p);
      checks++;
      if (p !== ref_prod(a, b) || lat !== 16 || lv !== ref_load(b)) begin
        failures++;
        $display("FAIL random%0d: a=%h b=%h product=%h latency=%0d load=%h required %h 16 %h",
                 i, a, b, p, lat, lv, ref_prod(a, b), ref_load(b));
      end
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b0;
    bus.start_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_basic();
    test_negative();
    test_corners();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
